// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered issue stage between decode and the ALU.
// Decodes ALUOp/funct into a 4-bit ALU control code, selects operand B and
// buffers up to two operations in order. The head entry lives in dedicated
// output registers, so the outputs hold their last value when the stage is
// empty. in_ready is derived only from the registered count.
module alu_issue_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alu_op,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_5,
  input  logic             in_op_5,
  input  logic             in_alu_src,
  input  logic [31:0]      in_rs1_data,
  input  logic [31:0]      in_rs2_data,
  input  logic [31:0]      in_imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [3:0]       out_alu_ctrl,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [3:0] CTRL_AND     = 4'b0000;
  localparam logic [3:0] CTRL_OR      = 4'b0001;
  localparam logic [3:0] CTRL_ADD     = 4'b0010;
  localparam logic [3:0] CTRL_SUB     = 4'b0110;
  localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

  localparam logic [1:0]       FULL    = 2'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        ill;
  } entry_t;

  // Translate ALUOp/funct fields into the ALU control code.
  function automatic logic [3:0] decode_ctrl(input logic [1:0] alu_op,
                                             input logic [2:0] funct3,
                                             input logic       op_5,
                                             input logic       funct7_5);
    logic [3:0] ctrl;
    ctrl = CTRL_ILLEGAL;
    case (alu_op)
      2'b00: ctrl = CTRL_ADD;
      2'b01: ctrl = CTRL_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  ctrl = (op_5 & funct7_5) ? CTRL_SUB : CTRL_ADD;
          3'b111:  ctrl = CTRL_AND;
          3'b110:  ctrl = CTRL_OR;
          default: ctrl = CTRL_ILLEGAL;
        endcase
      end
      default: ctrl = CTRL_ILLEGAL;
    endcase
    return ctrl;
  endfunction

  logic [1:0]       count_q, count_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  entry_t           new_entry;
  logic             push;
  logic             pop;

  assign in_ready      = (count_q != FULL);
  assign out_valid     = (count_q != 2'd0);
  assign out_a         = head_q.a;
  assign out_b         = head_q.b;
  assign out_alu_ctrl  = head_q.ctrl;
  assign out_illegal   = head_q.ill;
  assign illegal_count = ill_cnt_q;

  // Decode the incoming operation and compute the next buffer/counter state.
  always_comb begin
    push           = in_valid & in_ready & ~flush;
    pop            = out_valid & out_ready & ~flush;
    new_entry.a    = in_rs1_data;
    new_entry.b    = in_alu_src ? in_imm : in_rs2_data;
    new_entry.ctrl = decode_ctrl(in_alu_op, in_funct3, in_op_5, in_funct7_5);
    new_entry.ill  = (new_entry.ctrl == CTRL_ILLEGAL);
    count_d        = count_q;
    head_d         = head_q;
    tail_d         = tail_q;
    ill_cnt_d      = ill_cnt_q;

    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = new_entry;
          else                 tail_d = new_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          // Second entry moves up to the head; an emptied stage keeps its head.
          if (count_q == FULL) head_d = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry: the new operation replaces the head.
          if (count_q == FULL) begin
            head_d = tail_q;
            tail_d = new_entry;
          end else begin
            head_d = new_entry;
          end
        end
        default: ;
      endcase
    end

    if (push && new_entry.ill && (ill_cnt_q != CNT_MAX)) begin
      ill_cnt_d = ill_cnt_q + CNT_ONE;
    end
  end

  // Buffer, output and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
      ill_cnt_q <= '0;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: driver pushes expected results into a
// scoreboard queue on every accepted operation; an independent monitor pops
// and compares whenever the DUT hands an operation to the ALU side.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_alu_op = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7_5 = 1'b0;
  logic        in_op_5 = 1'b0;
  logic        in_alu_src = 1'b0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic [31:0] in_imm = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_alu_ctrl;
  logic        out_illegal;
  logic [15:0] illegal_count;

  alu_issue_stage #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct3(in_funct3),
    .in_funct7_5(in_funct7_5), .in_op_5(in_op_5), .in_alu_src(in_alu_src),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_ctrl(out_alu_ctrl),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt = '0;
  bit          stall = 1'b0;
  exp_t        prev;

  // Reference control-code table.
  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3,
                                          input logic op5, input logic f7);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    if (op == 2'd3) return 4'd15;
    if (f3 == 3'd0) return (op5 && f7) ? 4'd6 : 4'd2;
    if (f3 == 3'd7) return 4'd0;
    if (f3 == 3'd6) return 4'd1;
    return 4'd15;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic op5,
                        input logic f7, input logic src, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm);
    in_valid = 1'b1; in_alu_op = op; in_funct3 = f3; in_op_5 = op5;
    in_funct7_5 = f7; in_alu_src = src; in_rs1_data = rs1;
    in_rs2_data = rs2; in_imm = imm;
  endtask

  // Called at a falling edge with inputs set: record acceptance, advance a cycle.
  task automatic tick(output bit acc);
    exp_t e;
    #2;
    acc = in_valid && in_ready && !flush && rst_n;
    if (acc) begin
      e.a    = in_rs1_data;
      e.b    = in_alu_src ? in_imm : in_rs2_data;
      e.ctrl = ref_ctrl(in_alu_op, in_funct3, in_op_5, in_funct7_5);
      e.ill  = (e.ctrl == 4'd15);
      q.push_back(e);
      if (e.ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic op5,
                      input logic f7, input logic src, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [31:0] imm);
    bit acc;
    acc = 1'b0;
    set_op(op, f3, op5, f7, src, rs1, rs2, imm);
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  // Monitor: checks handshake state and pops the scoreboard on each hand-off.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      chk("illegal_count", {16'd0, illegal_count}, {16'd0, exp_cnt});
      if (stall) begin
        chk("stable_a", out_a, prev.a);
        chk("stable_b", out_b, prev.b);
        chk("stable_ctrl", {28'd0, out_alu_ctrl}, {28'd0, prev.ctrl});
        chk("stable_ill", {31'd0, out_illegal}, {31'd0, prev.ill});
      end
      if (flush) begin
        q.delete();
      end else if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("out_a", out_a, e.a);
        chk("out_b", out_b, e.b);
        chk("out_alu_ctrl", {28'd0, out_alu_ctrl}, {28'd0, e.ctrl});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      end
      stall     = out_valid && !out_ready && !flush;
      prev.a    = out_a;
      prev.b    = out_b;
      prev.ctrl = out_alu_ctrl;
      prev.ill  = out_illegal;
    end
  end

  initial begin
    bit          acc;
    int          guard;
    logic [15:0] saved;

    // Reset values before any clock edge.
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_ctrl", {28'd0, out_alu_ctrl}, 32'd0);
    chk("rst_ill", {31'd0, out_illegal}, 32'd0);
    chk("rst_cnt", {16'd0, illegal_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Directed decode cases.
    send(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 32'h10, 32'h3, 32'h0);
    chk("first_latency_valid", {31'd0, out_valid}, 32'd1);
    chk("first_ctrl", {28'd0, out_alu_ctrl}, 32'h6);
    send(2'b00, 3'b010, 1'b0, 1'b0, 1'b1, 32'h100, 32'h55, 32'hFFFFFFFC);
    send(2'b10, 3'b111, 1'b1, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'h0);
    send(2'b10, 3'b110, 1'b1, 1'b0, 1'b0, 32'hA5A5, 32'h5A5A, 32'h0);
    send(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'h7, 32'h9, 32'h11);
    idle(3);

    // Stall: two fill the buffer, the third is held off until release.
    out_ready = 1'b0;
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1, 32'h2, 32'h3);
    send(2'b01, 3'b000, 1'b0, 1'b0, 1'b1, 32'h4, 32'h5, 32'h6);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    set_op(2'b10, 3'b110, 1'b1, 1'b0, 1'b0, 32'h7, 32'h8, 32'h9);
    for (int i = 0; i < 3; i++) tick(acc);
    out_ready = 1'b1;
    send(2'b10, 3'b110, 1'b1, 1'b0, 1'b0, 32'h7, 32'h8, 32'h9);
    idle(4);

    // Illegal encodings travel in order and are counted.
    send(2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'hDEAD, 32'hBEEF, 32'h0);
    send(2'b10, 3'b001, 1'b1, 1'b0, 1'b0, 32'hCAFE, 32'hF00D, 32'h0);
    idle(3);
    chk("illegal_count_two", {16'd0, illegal_count}, 32'd2);

    // Flush with two buffered plus a simultaneous illegal push and pop.
    out_ready = 1'b0;
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h21, 32'h22, 32'h23);
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h31, 32'h32, 32'h33);
    saved = exp_cnt;
    set_op(2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'h41, 32'h42, 32'h43);
    out_ready = 1'b1;
    flush = 1'b1;
    tick(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_cnt", {16'd0, illegal_count}, {16'd0, saved});
    idle(2);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      set_op(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      tick(acc);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Saturation of the illegal-operation counter.
    set_op(2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'h5, 32'h6, 32'h7);
    guard = 0;
    while (exp_cnt != 16'hFFFF && guard < 70000) begin
      tick(acc);
      guard++;
    end
    for (int i = 0; i < 4; i++) tick(acc);
    in_valid = 1'b0;
    idle(3);
    chk("sat_cnt", {16'd0, illegal_count}, 32'h0000FFFF);

    // Asynchronous reset with two entries buffered.
    out_ready = 1'b0;
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h61, 32'h62, 32'h63);
    send(2'b10, 3'b111, 1'b0, 1'b0, 1'b0, 32'h71, 32'h72, 32'h73);
    #3;
    rst_n = 1'b0;
    q.delete();
    exp_cnt = '0;
    stall = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_a", out_a, 32'd0);
    chk("arst_out_b", out_b, 32'd0);
    chk("arst_ctrl", {28'd0, out_alu_ctrl}, 32'd0);
    chk("arst_cnt", {16'd0, illegal_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'h81, 32'h82, 32'h83);
    idle(3);
    chk("drain_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
